row_bias: RTL and testbench
===========================

Name: row_bias

Overview:
- Responder end of the tile value-request handshake; one instance per grid row.
- Holds a per-row random permutation ("bias") of the GRID_LEN one-hot values.
- Answers each tile's (rq_valtotry, biasidx) request with the permuted one-hot value on valtotry one cycle later.
- Builds the permutation after reset, and again on demand, by an LFSR-driven Fisher-Yates shuffle.

Parameters:
- LEN, `GRID_LEN, number of tiles and values in the row.
- LFSR_W, 16, width of the internal Galois LFSR.
- SEED, 16'hACE1, LFSR load value at reset; a SEED of 0 is replaced by 1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- reshuffle  in  1  pulse; request a new permutation. Accepted only while ready is high.
- rq_valtotry  in  LEN  one bit per tile in the row; tile t requests a lookup.
- biasidx  in  LEN*LEN  flattened; slice [t*LEN +: LEN] is tile t's one-hot index, or zero.
- valtotry  out  LEN  registered one-hot reply, or zero.
- ready  out  1  high when the permutation is stable and requests are serviced.
- collide  out  1  sticky flag; more than one rq_valtotry bit was seen high in the same cycle.

Behaviour:
- Reset values: state=INIT; valtotry=0; ready=0; collide=0; lfsr=SEED (1 if SEED==0). perm contents are don't-care.
- Storage: perm[0..LEN-1], each LEN bits, one-hot. Must always be a permutation of {1<<0 .. 1<<(LEN-1)} whenever ready=1.
- Shuffle cursor i: width $clog2(LEN). Candidate j = low $clog2(LEN) bits of the next lfsr value.
- State machine, one transition per clock:
  - INIT: perm[k] <= 1<<k for all k; i <= LEN-1; go to SHUFFLE.
  - SHUFFLE:
    - Every cycle: lfsr advances one step (right-shift Galois; when lsb=1, XOR with 16'hB400).
    - If j <= i: swap perm[i] and perm[j]; i <= i-1. A swap with j==i is a legal no-op swap.
    - If j > i: no swap; i holds (rejection sampling retry).
    - When a swap occurs with i==1: go to READY next cycle.
    - LEN==1: go directly to READY.
  - READY:
    - ready=1.
    - reshuffle=1: i <= LEN-1 and go to SHUFFLE. The current perm is kept as the starting point; lfsr continues from its current value.
- Request service, in READY only:
  - Selected tile t = lowest index with rq_valtotry[t]=1.
  - Next cycle: valtotry <= OR over k of (biasidx_t[k] ? perm[k] : 0).
  - biasidx_t == 0 (tile's empty/exhausted index) gives valtotry=0 next cycle.
  - A non-one-hot biasidx gives the OR of the selected entries; not a supported use.
  - No rq bit set: valtotry <= 0. Reply is a one-cycle registered pulse, latency exactly 1, matching the tile's request-then-load sequencing.
  - Two or more rq bits high in the same cycle: lowest tile is serviced and collide <= 1. collide is cleared only by reset.
- Outside READY (INIT/SHUFFLE):
  - ready=0; valtotry <= 0; requests dropped, not queued.
  - reshuffle is ignored.
  - collide still updates.
- Simultaneous reshuffle and rq in READY: the request is serviced (reply valid next cycle, taken from the pre-shuffle perm), then SHUFFLE begins.
- Reset mid-shuffle or mid-reply: the synchronous reset wins. Next cycle: state=INIT, valtotry=0, ready=0, collide=0, lfsr=SEED.
- Determinism: identical SEED and stimulus give an identical permutation sequence. The bench computes the expected perm from a reference model of the same LFSR and shuffle.

Test Plan:
1. Reset, LEN=9, SEED default; wait for ready. Then rq tile 0 with biasidx=1<<k, k=0..8 on consecutive cycles -> 9 replies, each one-hot, pairwise distinct, equal to the model perm; each reply appears exactly 1 cycle after its request and is 0 in the following idle cycle.
2. In READY, rq tile 3 with biasidx=0 -> valtotry=0 next cycle; collide stays 0.
3. rq=9'b000010100, tile 2 index=1<<4, tile 4 index=1<<5 -> reply = perm[4] (tile 2 serviced); collide=1 and stays 1 until the next reset.
4. Pulse reshuffle together with rq (index 1<<0) -> reply = old perm[0] next cycle; ready drops the following cycle; requests during SHUFFLE give valtotry=0; new perm is a valid permutation matching the model.
5. Assert reset during SHUFFLE -> next cycle ready=0, valtotry=0, collide=0; the perm rebuilt afterwards equals the one from scenario 1.
6. SEED=0 -> behaves identically to SEED=1; over 1000 reshuffles every perm is a valid permutation and ready never stays low for more than 200 cycles.

Source files
------------

// File: rtl/row_bias.sv
// row_bias: per-row responder for the tile value-request handshake.
// Holds a one-hot permutation of the LEN values, rebuilt by an LFSR-driven
// Fisher-Yates shuffle after reset and on demand. Each request is answered
// with a registered reply exactly one cycle later.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module row_bias #(
   parameter int                LEN    = `GRID_LEN,
   parameter int                LFSR_W = 16,
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 reshuffle,
   input  logic [LEN-1:0]       rq_valtotry,
   input  logic [LEN*LEN-1:0]   biasidx,
   output logic [LEN-1:0]       valtotry,
   output logic                 ready,
   output logic                 collide
);

   localparam int                IW       = (LEN > 1) ? $clog2(LEN) : 1;
   // An all-zero Galois LFSR would lock up, so a zero seed is replaced by 1.
   localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;
   localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(16'hB400);
   localparam logic [IW-1:0]     I_TOP    = IW'(LEN - 1);

   typedef enum logic [1:0] {ST_INIT, ST_SHUFFLE, ST_READY} state_t;

   state_t              state_q, state_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d, lfsr_nxt;
   logic [IW-1:0]       i_q, i_d, j;
   logic [LEN-1:0]      perm_q [LEN];
   logic [LEN-1:0]      perm_d [LEN];
   logic [LEN-1:0]      valtotry_q, valtotry_d;
   logic [LEN-1:0]      sel_idx, reply;
   logic                collide_q, collide_d;
   logic                swap;

   // Candidate index comes from the LFSR value the shuffle is about to step to;
   // candidates above the cursor are rejected and retried on the next cycle.
   assign lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
   assign j        = lfsr_nxt[IW-1:0];
   assign swap     = (state_q == ST_SHUFFLE) && (j <= i_q);

   // Control state and outputs that have defined reset values
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_INIT;
         lfsr_q     <= SEED_EFF;
         valtotry_q <= '0;
         collide_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         valtotry_q <= valtotry_d;
         collide_q  <= collide_d;
      end
   end

   // Permutation storage and shuffle cursor; always rebuilt in INIT, so no reset
   always_ff @(posedge clock) begin
      i_q <= i_d;
      for (int k = 0; k < LEN; k++) begin
         perm_q[k] <= perm_d[k];
      end
   end

   // Next-state logic: INIT -> SHUFFLE -> READY, READY -> SHUFFLE on reshuffle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT:    state_d = ST_SHUFFLE;
         ST_SHUFFLE: begin
            if ((LEN == 1) || (swap && (i_q == IW'(1)))) begin
               state_d = ST_READY;
            end
         end
         ST_READY:   if (reshuffle) state_d = ST_SHUFFLE;
         default:    state_d = ST_INIT;
      endcase
   end

   // Shuffle datapath: identity load, swap-and-decrement, or rejection retry
   always_comb begin
      lfsr_d = lfsr_q;
      i_d    = i_q;
      for (int k = 0; k < LEN; k++) begin
         perm_d[k] = perm_q[k];
      end
      case (state_q)
         ST_INIT: begin
            for (int k = 0; k < LEN; k++) begin
               perm_d[k]    = '0;
               perm_d[k][k] = 1'b1;
            end
            i_d = I_TOP;
         end
         ST_SHUFFLE: begin
            lfsr_d = lfsr_nxt;
            if (swap) begin
               perm_d[i_q] = perm_q[j];
               perm_d[j]   = perm_q[i_q];
               i_d         = i_q - IW'(1);
            end
         end
         ST_READY: begin
            if (reshuffle) i_d = I_TOP;
         end
         default: ;
      endcase
   end

   // Request service: lowest requesting tile wins; collisions are sticky
   always_comb begin
      sel_idx = '0;
      for (int t = LEN - 1; t >= 0; t--) begin
         if (rq_valtotry[t]) sel_idx = biasidx[t*LEN +: LEN];
      end
      reply = '0;
      for (int k = 0; k < LEN; k++) begin
         if (sel_idx[k]) reply = reply | perm_q[k];
      end
      valtotry_d = (state_q == ST_READY) ? reply : '0;
      collide_d  = collide_q | ((rq_valtotry & (rq_valtotry - LEN'(1))) != '0);
   end

   // Outputs
   always_comb begin
      ready    = (state_q == ST_READY);
      valtotry = valtotry_q;
      collide  = collide_q;
   end

endmodule

// File: tb/tb_row_bias.sv
// Bench for row_bias: table-driven vectors, randomized requests and
// hand-written multi-cycle sequences, checked against a Fisher-Yates model.
module tb_row_bias;

   localparam int LEN  = 9;
   localparam int IW   = 4;
   localparam int MASK = (1 << IW) - 1;
   localparam logic [15:0] SEED_A = 16'hACE1;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic                reset_a, resh_a, ready_a, col_a;
   logic [LEN-1:0]      rq_a, val_a;
   logic [LEN*LEN-1:0]  bidx_a;
   logic                reset_b, resh_b, ready_b, col_b;
   logic [LEN-1:0]      rq_b, val_b;
   logic [LEN*LEN-1:0]  bidx_b;

   row_bias #(.LEN(LEN)) dut_a (
      .clock(clock), .reset(reset_a), .reshuffle(resh_a), .rq_valtotry(rq_a),
      .biasidx(bidx_a), .valtotry(val_a), .ready(ready_a), .collide(col_a));

   row_bias #(.LEN(LEN), .SEED(16'h0000)) dut_b (
      .clock(clock), .reset(reset_b), .reshuffle(resh_b), .rq_valtotry(rq_b),
      .biasidx(bidx_b), .valtotry(val_b), .ready(ready_b), .collide(col_b));

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0]    m_lfsr [2];
   logic [LEN-1:0] m_perm [2][LEN];
   logic [LEN-1:0] got_perm [LEN];
   logic [LEN-1:0] perm1 [LEN];

   typedef struct {
      logic [LEN-1:0]     rq;
      logic [LEN*LEN-1:0] bidx;
      int                 exp_k;
      logic               exp_col;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string nm, input int unsigned got, input int unsigned exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [LEN-1:0] oh(input int k);
      logic [LEN-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   function automatic logic [LEN*LEN-1:0] mk_bidx(input int t, input logic [LEN-1:0] idx);
      logic [LEN*LEN-1:0] v;
      v = '0;
      v[t*LEN +: LEN] = idx;
      return v;
   endfunction

   function automatic logic [15:0] lstep(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic model_reset(input int w, input logic [15:0] seed);
      m_lfsr[w] = (seed == 16'h0) ? 16'h0001 : seed;
      for (int k = 0; k < LEN; k++) m_perm[w][k] = oh(k);
   endtask

   // Fisher-Yates from the top down, drawing with rejection until j <= i
   task automatic model_shuffle(input int w);
      for (int i = LEN - 1; i >= 1; i--) begin
         int j;
         logic [LEN-1:0] tmp;
         do begin
            m_lfsr[w] = lstep(m_lfsr[w]);
            j = int'(m_lfsr[w]) & MASK;
         end while (j > i);
         tmp          = m_perm[w][i];
         m_perm[w][i] = m_perm[w][j];
         m_perm[w][j] = tmp;
      end
   endtask

   function automatic logic [LEN-1:0] model_reply(input logic [LEN-1:0] rq,
                                                  input logic [LEN*LEN-1:0] b);
      logic [LEN-1:0] r;
      r = '0;
      for (int t = 0; t < LEN; t++) begin
         if (rq[t]) begin
            for (int k = 0; k < LEN; k++) if (b[t*LEN + k]) r = r | m_perm[0][k];
            break;
         end
      end
      return r;
   endfunction

   task automatic drive(input int w, input logic [LEN-1:0] rq,
                        input logic [LEN*LEN-1:0] b, input logic rs);
      if (w == 0) begin rq_a = rq; bidx_a = b; resh_a = rs; end
      else        begin rq_b = rq; bidx_b = b; resh_b = rs; end
   endtask

   function automatic logic [LEN-1:0] val_of(input int w);
      return (w == 0) ? val_a : val_b;
   endfunction

   function automatic logic rdy_of(input int w);
      return (w == 0) ? ready_a : ready_b;
   endfunction

   task automatic wait_ready(input int w, input string nm);
      int c;
      c = 0;
      while (!rdy_of(w) && c < 200) begin
         step();
         c++;
      end
      chk(nm, rdy_of(w), 1);
   endtask

   // Reads the permutation by requesting each index from tile 0 on back-to-back cycles
   task automatic read_perm(input int w, input logic per_entry);
      for (int k = 0; k < LEN; k++) begin
         drive(w, oh(0), mk_bidx(0, oh(k)), 1'b0);
         step();
         got_perm[k] = val_of(w);
         if (per_entry) chk($sformatf("perm[%0d]", k), got_perm[k], m_perm[w][k]);
      end
      drive(w, '0, '0, 1'b0);
      step();
      chk("idle after reply", val_of(w), 0);
   endtask

   function automatic int perm_mism(input int w);
      int n;
      n = 0;
      for (int k = 0; k < LEN; k++) if (got_perm[k] !== m_perm[w][k]) n++;
      return n;
   endfunction

   function automatic int perm_valid();
      logic [LEN-1:0] acc;
      acc = '0;
      for (int k = 0; k < LEN; k++) begin
         if ($countones(got_perm[k]) != 1) return 0;
         acc = acc | got_perm[k];
      end
      return (acc == {LEN{1'b1}}) ? 1 : 0;
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [LEN-1:0] exp_v, old0;
      logic [LEN-1:0] rq;
      logic [LEN*LEN-1:0] b;
      int mism;

      tbl[0] = '{rq: oh(3),          bidx: '0,                                    exp_k: -1, exp_col: 1'b0};
      tbl[1] = '{rq: '0,             bidx: mk_bidx(0, oh(2)),                     exp_k: -1, exp_col: 1'b0};
      tbl[2] = '{rq: oh(8),          bidx: mk_bidx(8, oh(7)),                     exp_k:  7, exp_col: 1'b0};
      tbl[3] = '{rq: oh(5),          bidx: mk_bidx(5, oh(0)),                     exp_k:  0, exp_col: 1'b0};
      tbl[4] = '{rq: oh(2) | oh(4),  bidx: mk_bidx(2, oh(4)) | mk_bidx(4, oh(5)), exp_k:  4, exp_col: 1'b1};
      tbl[5] = '{rq: oh(1),          bidx: mk_bidx(1, oh(8)),                     exp_k:  8, exp_col: 1'b1};
      tbl[6] = '{rq: oh(7) | oh(8),  bidx: mk_bidx(7, oh(3)) | mk_bidx(8, oh(6)), exp_k:  3, exp_col: 1'b1};

      reset_a = 1'b1; reset_b = 1'b1;
      drive(0, '0, '0, 1'b0);
      drive(1, '0, '0, 1'b0);
      step();
      step();
      chk("reset ready", ready_a, 0);
      chk("reset valtotry", val_a, 0);
      chk("reset collide", col_a, 0);

      // Scenario 1: first permutation after reset
      reset_a = 1'b0;
      model_reset(0, SEED_A);
      model_shuffle(0);
      wait_ready(0, "ready after reset");
      read_perm(0, 1'b1);
      chk("perm1 valid", perm_valid(), 1);
      for (int k = 0; k < LEN; k++) perm1[k] = got_perm[k];

      // Scenarios 2 and 3 plus more single-cycle vectors
      foreach (tbl[n]) begin
         drive(0, tbl[n].rq, tbl[n].bidx, 1'b0);
         step();
         exp_v = (tbl[n].exp_k < 0) ? '0 : m_perm[0][tbl[n].exp_k];
         chk($sformatf("tbl%0d valtotry", n), val_a, exp_v);
         chk($sformatf("tbl%0d collide", n), col_a, tbl[n].exp_col);
      end

      // Randomized requests in READY
      for (int n = 0; n < 40; n++) begin
         rq = LEN'($urandom_range(0, (1 << LEN) - 1));
         b  = '0;
         for (int t = 0; t < LEN; t++) begin
            int r;
            r = $urandom_range(0, LEN);
            if (r < LEN) b[t*LEN +: LEN] = oh(r);
         end
         drive(0, rq, b, 1'b0);
         step();
         chk("rand valtotry", val_a, model_reply(rq, b));
         chk("rand collide sticky", col_a, 1);
      end

      // Scenario 4: reshuffle together with a request
      old0 = m_perm[0][0];
      drive(0, oh(0), mk_bidx(0, oh(0)), 1'b1);
      step();
      chk("reply with reshuffle", val_a, old0);
      chk("ready drops", ready_a, 0);
      drive(0, oh(0), mk_bidx(0, oh(3)), 1'b0);
      step();
      chk("rq during shuffle", val_a, 0);
      drive(0, '0, '0, 1'b0);
      model_shuffle(0);
      wait_ready(0, "ready after reshuffle");
      read_perm(0, 1'b1);
      chk("perm2 valid", perm_valid(), 1);
      chk("collide held", col_a, 1);

      // Scenario 5: reset during SHUFFLE
      drive(0, '0, '0, 1'b1);
      step();
      drive(0, '0, '0, 1'b0);
      step();
      step();
      chk("still shuffling", ready_a, 0);
      reset_a = 1'b1;
      drive(0, oh(0), mk_bidx(0, oh(0)), 1'b0);
      step();
      chk("mid-shuffle reset ready", ready_a, 0);
      chk("mid-shuffle reset valtotry", val_a, 0);
      chk("mid-shuffle reset collide", col_a, 0);
      reset_a = 1'b0;
      drive(0, '0, '0, 1'b0);
      model_reset(0, SEED_A);
      model_shuffle(0);
      wait_ready(0, "ready after re-reset");
      read_perm(0, 1'b0);
      chk("rebuilt perm vs model", perm_mism(0), 0);
      mism = 0;
      for (int k = 0; k < LEN; k++) if (got_perm[k] !== perm1[k]) mism++;
      chk("rebuilt perm vs first", mism, 0);

      // Scenario 6: SEED=0 instance behaves as SEED=1 across many reshuffles
      reset_b = 1'b0;
      model_reset(1, 16'h0001);
      for (int it = 0; it < 1000; it++) begin
         model_shuffle(1);
         wait_ready(1, "seed0 ready bound");
         read_perm(1, 1'b0);
         chk("seed0 perm vs model", perm_mism(1), 0);
         chk("seed0 perm valid", perm_valid(), 1);
         drive(1, '0, '0, 1'b1);
         step();
         drive(1, '0, '0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
